// File: rtl/rf_pkg.sv
// Shared register-file types for the write-back path: address/data widths and
// the staged write record driven onto one regfile write port.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic            rw;
        reg_addr_t       addr;
        logic [XLEN-1:0] data;
    } rf_wr_t;

    // One-hot of a register index, suppressed when the port is not writing.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a, input logic en);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[a] = en;
        return v;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Circular find-first-set: returns the first set bit of mask_i at or after start_i,
// wrapping around, together with a found flag.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]                          mask_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  start_i,
    output logic                                  found_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  idx_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Scan from the far end so the nearest candidate to start_i is written last.
    always_comb begin
        int j;
        j       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start_i) + k) % N;
            if (mask_i[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: shares the two regfile write ports among NUM_REQ producers,
// round-robin, with same-register collision blocking and x0 write suppression.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][4:0]           req_addr_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic                              rf_rw1_o,
    output logic [31:0]                       rf_addr1_o,
    output logic [XLEN-1:0]                   rf_data1_o,
    output logic                              rf_rw2_o,
    output logic [31:0]                       rf_addr2_o,
    output logic [XLEN-1:0]                   rf_data2_o,
    output logic [31:0]                       busy_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    rf_wr_t              wr1_q, wr1_d, wr2_q, wr2_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic                f1, f2;
    logic [IW-1:0]       i1, i2, start2;
    logic [NUM_REQ-1:0]  mask2, gnt;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : IW'(int'(i) + 1);
    endfunction

    rr_pick #(.N(NUM_REQ)) u_pick1 (
        .mask_i  (req_valid_i),
        .start_i (rr_ptr_q),
        .found_o (f1),
        .idx_o   (i1)
    );

    // Second pick excludes the first winner and anything colliding on a real register.
    always_comb begin
        mask2  = req_valid_i;
        start2 = next_idx(i1);
        if (f1) begin
            mask2[i1] = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req_addr_i[i1] != '0 && req_addr_i[j] == req_addr_i[i1])
                    mask2[j] = 1'b0;
            end
        end else begin
            mask2 = '0;
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick2 (
        .mask_i  (mask2),
        .start_i (start2),
        .found_o (f2),
        .idx_o   (i2)
    );

    always_comb begin
        gnt = '0;
        if (f1) gnt[i1] = 1'b1;
        if (f2) gnt[i2] = 1'b1;

        rr_ptr_d = rr_ptr_q;
        if (f2)      rr_ptr_d = next_idx(i2);
        else if (f1) rr_ptr_d = next_idx(i1);

        // x0 grants consume their slot but leave the port idle with zeroed fields.
        wr1_d = '0;
        if (f1 && req_addr_i[i1] != '0) begin
            wr1_d.rw   = 1'b1;
            wr1_d.addr = req_addr_i[i1];
            wr1_d.data = req_data_i[i1];
        end
        wr2_d = '0;
        if (f2 && req_addr_i[i2] != '0) begin
            wr2_d.rw   = 1'b1;
            wr2_d.addr = req_addr_i[i2];
            wr2_d.data = req_data_i[i2];
        end

        busy_d = reg_onehot(wr1_d.addr, wr1_d.rw) | reg_onehot(wr2_d.addr, wr2_d.rw);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            wr1_q    <= '0;
            wr2_q    <= '0;
            busy_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr1_q    <= wr1_d;
            wr2_q    <= wr2_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready_o = gnt & {NUM_REQ{rst_ni}};
    assign rf_rw1_o    = wr1_q.rw;
    assign rf_addr1_o  = {{(32-REG_ADDR_W){1'b0}}, wr1_q.addr};
    assign rf_data1_o  = wr1_q.data;
    assign rf_rw2_o    = wr2_q.rw;
    assign rf_addr2_o  = {{(32-REG_ADDR_W){1'b0}}, wr2_q.addr};
    assign rf_data2_o  = wr2_q.data;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps followed by a random soak,
// all checked against a list-based round-robin model and a shadow regfile.
module tb_rf_wb_arbiter;

    localparam int N  = 4;
    localparam int XL = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [N-1:0]           req_valid_i = '0;
    logic [N-1:0][4:0]      req_addr_i = '0;
    logic [N-1:0][XL-1:0]   req_data_i = '0;
    logic [N-1:0]           req_ready_o;
    logic                   rf_rw1_o, rf_rw2_o;
    logic [31:0]            rf_addr1_o, rf_addr2_o;
    logic [XL-1:0]          rf_data1_o, rf_data2_o;
    logic [31:0]            busy_o;

    rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rf_rw1_o    (rf_rw1_o),
        .rf_addr1_o  (rf_addr1_o),
        .rf_data1_o  (rf_data1_o),
        .rf_rw2_o    (rf_rw2_o),
        .rf_addr2_o  (rf_addr2_o),
        .rf_data2_o  (rf_data2_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          failures = 0;
    int          m_ptr = 0;
    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32];
    logic [N-1:0] last_gnt;
    int          wcnt [N];
    bit          fair_en = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Valid requesters listed in pointer order; first entry wins port 1, the next
    // one not colliding on a real register wins port 2.
    function automatic logic [N-1:0] model_grant(input int ptr, output int g1, output int g2);
        int q[$];
        logic [N-1:0] r;
        r = '0; g1 = -1; g2 = -1;
        for (int k = 0; k < N; k++)
            if (req_valid_i[(ptr + k) % N]) q.push_back((ptr + k) % N);
        if (q.size() > 0) begin
            g1 = q[0]; r[g1] = 1'b1;
            for (int k = 1; k < q.size(); k++) begin
                if (!(req_addr_i[q[k]] == req_addr_i[g1] && req_addr_i[g1] != 0)) begin
                    g2 = q[k]; r[g2] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic clear_rfs();
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end
    endtask

    // Called at posedge+1; checks the grant mid-cycle and the staged write after the edge.
    task automatic cycle(input string tag);
        int g1, g2;
        logic [N-1:0] er;
        logic e_rw1, e_rw2;
        logic [4:0] e_a1, e_a2;
        logic [31:0] e_d1, e_d2, e_busy;
        #3;
        er = model_grant(m_ptr, g1, g2);
        chk({tag, "/ready"}, 64'(req_ready_o), 64'(er));
        if (fair_en) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid_i[i]) wcnt[i]++;
                if (req_ready_o[i]) begin
                    chk({tag, "/fair_bound"}, 64'(wcnt[i] <= (N + 1) / 2), 64'(1));
                    wcnt[i] = 0;
                end
            end
        end
        e_rw1 = (g1 >= 0) && req_addr_i[g1] != 0;
        e_a1  = e_rw1 ? req_addr_i[g1] : 5'd0;
        e_d1  = e_rw1 ? req_data_i[g1] : 32'd0;
        e_rw2 = (g2 >= 0) && req_addr_i[g2] != 0;
        e_a2  = e_rw2 ? req_addr_i[g2] : 5'd0;
        e_d2  = e_rw2 ? req_data_i[g2] : 32'd0;
        if (e_rw1) m_rf[e_a1] = e_d1;
        if (e_rw2) m_rf[e_a2] = e_d2;
        if (g2 >= 0)      m_ptr = (g2 + 1) % N;
        else if (g1 >= 0) m_ptr = (g1 + 1) % N;
        e_busy = '0;
        for (int r = 1; r < 32; r++)
            e_busy[r] = (e_rw1 && e_a1 == r) || (e_rw2 && e_a2 == r);
        last_gnt = er;
        @(posedge clk_i); #1;
        chk({tag, "/rw1"},   64'(rf_rw1_o),   64'(e_rw1));
        chk({tag, "/addr1"}, 64'(rf_addr1_o), 64'(e_a1));
        chk({tag, "/rw2"},   64'(rf_rw2_o),   64'(e_rw2));
        chk({tag, "/addr2"}, 64'(rf_addr2_o), 64'(e_a2));
        if (e_rw1) chk({tag, "/data1"}, 64'(rf_data1_o), 64'(e_d1));
        if (e_rw2) chk({tag, "/data2"}, 64'(rf_data2_o), 64'(e_d2));
        chk({tag, "/busy"}, 64'(busy_o), 64'(e_busy));
        chk({tag, "/no_collide"},
            64'(rf_rw1_o && rf_rw2_o && rf_addr1_o == rf_addr2_o), 64'(0));
        if (rf_rw1_o) d_rf[rf_addr1_o[4:0]] = rf_data1_o;
        if (rf_rw2_o) d_rf[rf_addr2_o[4:0]] = rf_data2_o;
    endtask

    task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
        req_valid_i[i] = v;
        req_addr_i[i]  = a;
        req_data_i[i]  = d;
    endtask

    initial begin
        int n;
        bit seen;
        clear_rfs();
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Reset mid-traffic: outputs drop at once, then grants restart at requester 0.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + i);
        cycle("pre_rst");
        cycle("pre_rst2");
        #2 rst_ni = 1'b0;
        #1;
        chk("rst/rw1",   64'(rf_rw1_o),    64'(0));
        chk("rst/rw2",   64'(rf_rw2_o),    64'(0));
        chk("rst/busy",  64'(busy_o),      64'(0));
        chk("rst/ready", 64'(req_ready_o), 64'(0));
        @(posedge clk_i); #1 rst_ni = 1'b1;
        m_ptr = 0;
        clear_rfs();

        // All four held valid on x1..x4: pairs {0,1},{2,3},{0,1}.
        cycle("all4_a"); chk("all4_a/busy_const", 64'(busy_o), 64'(32'h6));
        cycle("all4_b"); chk("all4_b/busy_const", 64'(busy_o), 64'(32'h18));
        cycle("all4_c"); chk("all4_c/busy_const", 64'(busy_o), 64'(32'h6));

        // Single requester to x5.
        req_valid_i = '0;
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle("single");
        chk("single/addr1_const", 64'(rf_addr1_o), 64'(5));
        chk("single/data1_const", 64'(rf_data1_o), 64'(32'hDEADBEEF));
        chk("single/busy_const",  64'(busy_o),     64'(32'h20));
        req_valid_i = '0;

        // x0 write alongside x9.
        set_req(2, 1'b1, 5'd0, 32'h55);
        set_req(3, 1'b1, 5'd9, 32'h99);
        cycle("x0");
        chk("x0/ready_both", 64'(last_gnt), 64'(4'b1100));
        chk("x0/busy_const", 64'(busy_o),   64'(32'h200));
        req_valid_i = '0;

        // Same-register pair: serialised in grant order.
        set_req(0, 1'b1, 5'd7, 32'h11);
        set_req(1, 1'b1, 5'd7, 32'h22);
        cycle("same_a");
        chk("same_a/ready_req0", 64'(last_gnt), 64'(4'b0001));
        req_valid_i[0] = 1'b0;
        cycle("same_b");
        req_valid_i = '0;
        cycle("same_flush");
        chk("same/x7_final", 64'(d_rf[7]), 64'(32'h22));

        // Three continuously busy requesters, then req3 arrives.
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(10 + i), 32'h300 + i);
        repeat (2) begin
            cycle("busy3");
            for (int i = 0; i < 3; i++) if (last_gnt[i]) req_data_i[i] = $urandom;
        end
        set_req(3, 1'b1, 5'd13, 32'h313);
        n = 0; seen = 0;
        while (!seen && n < 8) begin
            cycle("late3");
            n++;
            seen = last_gnt[3];
            for (int i = 0; i < 3; i++) if (last_gnt[i]) req_data_i[i] = $urandom;
        end
        chk("late3/granted_within_2", 64'(seen && n <= 2), 64'(1));
        req_valid_i = '0;
        cycle("late3_flush");

        // Soak A: distinct registers per requester, fairness bound enforced.
        fair_en = 1;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid_i[i] || last_gnt[i]) begin
                    wcnt[i] = 0;
                    set_req(i, ($urandom_range(0, 9) < 7), 5'(8 * i + $urandom_range(0, 7)), $urandom);
                end
            end
            last_gnt = '0;
            cycle("soakA");
        end
        fair_en = 0;

        // Soak B: small shared register set, collisions and x0 frequent.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid_i[i] || last_gnt[i])
                    set_req(i, ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 5)), $urandom);
            last_gnt = '0;
            cycle("soakB");
        end
        req_valid_i = '0;
        cycle("drain");
        for (int r = 0; r < 32; r++)
            chk($sformatf("final_rf[%0d]", r), 64'(d_rf[r]), 64'(m_rf[r]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
